// File: rtl/sweep_ctrl_pkg.sv
// Shared types for the triangle-generator sweep sequencer: FSM states and
// the sweep direction tracked by the optional output checker.
package sweep_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    PAUSE,
    DONE
  } state_t;

  typedef enum logic {
    UP,
    DOWN
  } dir_t;

  function automatic logic is_busy(input state_t s);
    return (s == CLEAR) || (s == RUN) || (s == PAUSE);
  endfunction

endpackage

// File: rtl/sweep_controller_strobe_divider.sv
// Programmable prescaler: while not held, emits a one-cycle registered strobe
// every period+1 advancing cycles; hold freezes the count and blocks the strobe.
module strobe_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         hold,
  input  logic [W-1:0] period,
  output logic         strobe
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt    <= '0;
      strobe <= 1'b0;
    end else if (hold) begin
      strobe <= 1'b0;
    end else if (cnt == period) begin
      cnt    <= '0;
      strobe <= 1'b1;
    end else begin
      cnt    <= cnt + 1'b1;
      strobe <= 1'b0;
    end
  end

endmodule

// File: rtl/sweep_controller.sv
// Sequencer for one N-bit triangle generator: clear, paced step strobes and
// half-sweep counting. Define SWEEP_CONTROLLER_CHECK_EN to build the tri_out checker.
module sweep_controller
  import sweep_ctrl_pkg::*;
#(
  parameter int N          = 8,
  parameter int PRESCALE_W = 16,
  parameter int SWEEPS_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  abort,
  input  logic [PRESCALE_W-1:0] period,
  input  logic [SWEEPS_W-1:0]   sweeps,
  input  logic [N-1:0]          tri_out,
  output logic                  tri_rst,
  output logic                  tri_ena,
  output logic                  busy,
  output logic                  done,
  output logic [SWEEPS_W-1:0]   sweep_count,
  output logic                  tri_err
);

  // Index of the last step of a half-sweep (2^N-1 steps, counted from 0).
  localparam logic [N-1:0] STEP_LAST = {{(N-1){1'b1}}, 1'b0};

  state_t                state, state_next;
  logic [PRESCALE_W-1:0] period_q;
  logic [SWEEPS_W-1:0]   sweeps_q;
  logic [SWEEPS_W-1:0]   sweep_inc;
  logic [N-1:0]          step_cnt;
  logic                  start_acc;
  logic                  half_done;
  logic                  final_step;
  logic                  run_finished;
  logic                  div_hold;

  assign start_acc    = (state == IDLE) && start && !abort;
  assign half_done    = tri_ena && (step_cnt == STEP_LAST);
  assign sweep_inc    = sweep_count + 1'b1;
  assign final_step   = half_done && (sweeps_q != '0) && (sweep_inc == sweeps_q);
  // Covers a final step that landed in the same cycle pause was raised.
  assign run_finished = (sweeps_q != '0) && (sweep_count == sweeps_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (start_acc) state_next = CLEAR;
      CLEAR:   state_next = abort ? IDLE : RUN;
      RUN: begin
        if (abort)           state_next = IDLE;
        else if (pause)      state_next = PAUSE;
        else if (final_step) state_next = DONE;
      end
      PAUSE: begin
        if (abort)       state_next = IDLE;
        else if (!pause) state_next = run_finished ? DONE : RUN;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The strobe is registered, so the prescaler advances into RUN one cycle
  // ahead; this places the first strobe period+1 cycles after CLEAR.
  assign div_hold = (state_next != RUN);

  strobe_divider #(
    .W(PRESCALE_W)
  ) u_strobe_divider (
    .clk   (clk),
    .rst   (rst),
    .clear (start_acc),
    .hold  (div_hold),
    .period(period_q),
    .strobe(tri_ena)
  );

  // Counting follows tri_ena even on an aborting edge: an issued step is real.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_q    <= '0;
      sweeps_q    <= '0;
      step_cnt    <= '0;
      sweep_count <= '0;
    end else if (start_acc) begin
      period_q    <= period;
      sweeps_q    <= sweeps;
      step_cnt    <= '0;
      sweep_count <= '0;
    end else if (half_done) begin
      step_cnt    <= '0;
      sweep_count <= sweep_inc;
    end else if (tri_ena) begin
      step_cnt    <= step_cnt + 1'b1;
    end
  end

  assign tri_rst = (state == CLEAR);
  assign busy    = is_busy(state);
  assign done    = (state == DONE);

`ifdef SWEEP_CONTROLLER_CHECK_EN
  logic [N-1:0] mirror_pos;
  dir_t         mirror_dir;
  logic         err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mirror_pos <= '0;
      mirror_dir <= UP;
      err_q      <= 1'b0;
    end else begin
      if (start_acc)
        err_q <= 1'b0;
      else if (((state == RUN) || (state == PAUSE)) && (tri_out != mirror_pos))
        err_q <= 1'b1;

      if (state == CLEAR) begin
        mirror_pos <= '0;
        mirror_dir <= UP;
      end else if (tri_ena) begin
        mirror_pos <= (mirror_dir == UP) ? mirror_pos + 1'b1 : mirror_pos - 1'b1;
        if (half_done) mirror_dir <= (mirror_dir == UP) ? DOWN : UP;
      end
    end
  end

  assign tri_err = err_q;
`else
  logic unused_tri_out;
  assign unused_tri_out = ^tri_out;
  assign tri_err        = 1'b0;
`endif

endmodule

// File: doc/sweep_controller.md
# sweep_controller

Sequencer for one N-bit triangle generator in the etch-a-sketch datapath. It issues the generator's clear and step-enable strobes at a programmable rate and counts completed half-sweeps. It stops after a programmed number of half-sweeps or runs continuously. It sits between the user controls (start/pause/abort) and the triangle generator feeding the drawing axes.

## Interface
Parameters:
- N, 8, width of the driven triangle generator; one half-sweep = 2^N-1 steps
- PRESCALE_W, 16, width of the step period field
- SWEEPS_W, 8, width of the half-sweep count

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request to begin a run; ignored while busy
- pause  in  1  level; holds the run while high
- abort  in  1  one-cycle request to end the run immediately
- period  in  PRESCALE_W  step interval; one strobe every period+1 cycles; sampled on accepted start
- sweeps  in  SWEEPS_W  half-sweeps to run; 0 = continuous; sampled on accepted start
- tri_out  in  N  generator output, used only by the checker (see Configuration)
- tri_rst  out  1  clear to the generator
- tri_ena  out  1  step strobe to the generator
- busy  out  1  high in CLEAR, RUN and PAUSE
- done  out  1  one-cycle pulse on normal completion
- sweep_count  out  SWEEPS_W  half-sweeps completed in the current or last run
- tri_err  out  1  sticky mismatch flag; tied 0 when the checker is compiled out

## Operation
- States: IDLE, CLEAR, RUN, PAUSE, DONE.
- IDLE: start -> CLEAR. Latch period and sweeps. Clear sweep_count, step counter, prescaler and tri_err.
- CLEAR: tri_rst=1 for exactly one cycle, then -> RUN. Mirror position = 0, direction = up.
- RUN:
  - Prescaler counts 0..period_q.
  - At period_q, tri_ena=1 for one cycle and the prescaler returns to 0.
  - Each tri_ena increments the step counter.
  - On the 2^N-1th step: step counter -> 0, sweep_count +1, mirror direction flips.
- Completion: if sweeps_q != 0 and sweep_count reaches sweeps_q -> DONE. With sweeps_q = 0 the run continues; sweep_count wraps modulo 2^SWEEPS_W.
- DONE: done=1 for one cycle -> IDLE. sweep_count holds its value.
- PAUSE:
  - Entered from RUN while pause=1. Prescaler and step counters hold; tri_ena=0.
  - pause=0 -> RUN, resuming the prescaler count where it stopped.
- abort: from any non-IDLE state -> IDLE next cycle. No done pulse; sweep_count holds.
- Priority: rst > abort > pause > completion > normal counting.
- A start in the same cycle as abort is ignored.
- When the final step and abort coincide, abort wins: no done pulse, though sweep_count includes the final half-sweep.
- pause held in the cycle a strobe would fire: the strobe is suppressed and fires after resume.
- tri_rst and tri_ena are never high in the same cycle.
- rst mid-run: every register returns to its reset value next cycle; no done pulse.

## Timing
- Reset values: state IDLE; tri_rst=0, tri_ena=0, busy=0, done=0, sweep_count=0, tri_err=0.
- start accepted at edge t -> tri_rst high during cycle t+1; first tri_ena during cycle t+2+period.
- Strobe spacing in RUN is exactly period+1 cycles; period=0 gives tri_ena every cycle.
- done asserts the cycle after the edge that registers the final step.
- All outputs are registered or decoded directly from state; no input-to-output combinational path.

## Configuration
- Macro: SWEEP_CONTROLLER_CHECK_EN.
- Defined:
  - Maintain an ideal mirror position: 0 -> 2^N-1 -> 0, stepping on each tri_ena.
  - In RUN and PAUSE, compare the mirror with tri_out every cycle; a mismatch sets tri_err.
  - tri_err is sticky until the next accepted start or rst.
- Undefined: no mirror or comparator logic; tri_err tied 0; tri_out unused.

## Structure
- Package sweep_ctrl_pkg holds state_t (the five states) and the direction enum (UP, DOWN).
- One sub-module, strobe_divider: PRESCALE_W prescaler with hold input and single-cycle strobe output, instantiated once for tri_ena.

## Test plan
Bench parameters: N=4 (15 steps per half-sweep). The bench drives tri_out from an ideal generator model.
- Reset then idle 10 cycles -> all outputs 0, no tri_ena.
- start, period=2, sweeps=2 -> tri_rst one cycle at t+1. tri_ena every 3 cycles, first at t+4. sweep_count 1 after 15 strobes. done pulse after 30 strobes, then busy=0.
- period=0, sweeps=0 -> tri_ena every cycle; sweep_count reaches 17 after 255 strobes; no done.
- pause high for 7 cycles mid-run at period=3 -> no tri_ena while paused. Next strobe follows resume after the remaining prescale count. Total strobes unchanged.
- abort after 20 strobes (sweeps=3) -> IDLE next cycle, no done, sweep_count=1. A start in the same cycle is ignored.
- Checker build: force the model's tri_out off by 1 after strobe 5 -> tri_err high next cycle, stays high until the next start.
